roimager_readout: RTL and testbench

ADC readout FSM for imager #1, the responder side of the FSMIND0/FSMIND1 frame handshake driven by the exposure FSM. It accepts a frame-end indication (FSMIND1) and acknowledges it. It then sequences row select, settle, sample and ADC conversion over every pixel row. Finally it hands control back to the exposure FSM with FSMIND0 and waits for FSMIND0ACK.

---
 rtl/roimager_pkg.sv | 41 ++++
 rtl/roimager_readout_if.sv | 30 +++
 rtl/roimager_readout.sv | 122 ++++++++++++
 tb/tb_roimager_readout.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roimager_pkg.sv
// Shared definitions for the imager #1 readout FSM and its exposure-side peer.
// Holds the one-hot state encoding, the fsm_stat codes and the default row count.
package roimager_pkg;

   localparam int C_NUM_ROWS_DEF = 160;

   typedef enum logic [7:0] {
      S_IDLE    = 8'b0000_0001,
      S_ACK     = 8'b0000_0010,
      S_ROW_SEL = 8'b0000_0100,
      S_SETTLE  = 8'b0000_1000,
      S_SAMPLE  = 8'b0001_0000,
      S_CONV    = 8'b0010_0000,
      S_NEXT    = 8'b0100_0000,
      S_DONE    = 8'b1000_0000
   } state_t;

   localparam logic [7:0] STAT_IDLE    = 8'hE0;
   localparam logic [7:0] STAT_ACK     = 8'hE1;
   localparam logic [7:0] STAT_ROW_SEL = 8'hE2;
   localparam logic [7:0] STAT_SETTLE  = 8'hE3;
   localparam logic [7:0] STAT_SAMPLE  = 8'hE4;
   localparam logic [7:0] STAT_CONV    = 8'hE5;
   localparam logic [7:0] STAT_NEXT    = 8'hE6;
   localparam logic [7:0] STAT_DONE    = 8'hE7;

   // Any non one-hot encoding reports as idle, matching the recovery target.
   function automatic logic [7:0] stat_of(input state_t s);
      case (s)
         S_ACK:     return STAT_ACK;
         S_ROW_SEL: return STAT_ROW_SEL;
         S_SETTLE:  return STAT_SETTLE;
         S_SAMPLE:  return STAT_SAMPLE;
         S_CONV:    return STAT_CONV;
         S_NEXT:    return STAT_NEXT;
         S_DONE:    return STAT_DONE;
         default:   return STAT_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/roimager_readout_if.sv
// Frame handshake, row/ADC control and status bundle of the imager #1 readout.
// The slave side is the readout FSM; the master side is the exposure FSM / ADC environment.
interface roimager_readout_if;

   logic        FSMIND1;
   logic        FSMIND1ACK;
   logic        FSMIND0;
   logic        FSMIND0ACK;
   logic [7:0]  ROW_ADDR;
   logic        ROW_EN;
   logic        ADC_SAMPLE;
   logic        ADC_DONE;
   logic        ERR_TIMEOUT;
   logic [31:0] CntRow;
   logic [31:0] CntFrame;
   logic [7:0]  fsm_stat;

   modport master (
      output FSMIND1, FSMIND0ACK, ADC_DONE,
      input  FSMIND1ACK, FSMIND0, ROW_ADDR, ROW_EN, ADC_SAMPLE,
             ERR_TIMEOUT, CntRow, CntFrame, fsm_stat
   );

   modport slave (
      input  FSMIND1, FSMIND0ACK, ADC_DONE,
      output FSMIND1ACK, FSMIND0, ROW_ADDR, ROW_EN, ADC_SAMPLE,
             ERR_TIMEOUT, CntRow, CntFrame, fsm_stat
   );

endinterface

// File: rtl/roimager_readout.sv
// ADC readout FSM for imager #1: answers the exposure FSM's frame-end request,
// walks every pixel row through select/settle/sample/convert, then hands control back.
module roimager_readout
   import roimager_pkg::*;
#(
   parameter int C_NUM_ROWS    = C_NUM_ROWS_DEF,
   parameter int C_ROW_SETTLE  = 4,
   parameter int C_ADC_TIMEOUT = 64
) (
   input  logic             CLKMPRE,
   input  logic             RESET,
   roimager_readout_if.slave bus
);

   localparam logic [7:0]  LAST_ROW   = 8'(C_NUM_ROWS - 1);
   localparam logic [15:0] SETTLE_END = 16'(C_ROW_SETTLE - 1);
   localparam logic [15:0] CONV_END   = 16'(C_ADC_TIMEOUT - 1);

   state_t      state;
   logic [7:0]  row;
   logic [15:0] timer;

   // The settle and conversion phases never overlap, so they share one timer.
   always_ff @(posedge CLKMPRE) begin
      if (RESET) begin
         state           <= S_IDLE;
         row             <= '0;
         timer           <= '0;
         bus.FSMIND1ACK  <= 1'b0;
         bus.FSMIND0     <= 1'b0;
         bus.ROW_ADDR    <= '0;
         bus.ROW_EN      <= 1'b0;
         bus.ADC_SAMPLE  <= 1'b0;
         bus.ERR_TIMEOUT <= 1'b0;
         bus.CntRow      <= '0;
         bus.CntFrame    <= '0;
         bus.fsm_stat    <= STAT_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.FSMIND1) begin
                  bus.FSMIND1ACK <= 1'b1;
                  bus.CntRow     <= '0;
                  row            <= '0;
                  state          <= S_ACK;
                  bus.fsm_stat   <= stat_of(S_ACK);
               end
            end
            S_ACK: begin
               state        <= S_ROW_SEL;
               bus.fsm_stat <= stat_of(S_ROW_SEL);
            end
            S_ROW_SEL: begin
               bus.ROW_ADDR <= row;
               bus.ROW_EN   <= 1'b1;
               timer        <= '0;
               state        <= S_SETTLE;
               bus.fsm_stat <= stat_of(S_SETTLE);
            end
            S_SETTLE: begin
               if (timer == SETTLE_END) begin
                  state        <= S_SAMPLE;
                  bus.fsm_stat <= stat_of(S_SAMPLE);
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            S_SAMPLE: begin
               bus.ADC_SAMPLE <= 1'b1;
               timer          <= '0;
               state          <= S_CONV;
               bus.fsm_stat   <= stat_of(S_CONV);
            end
            S_CONV: begin
               bus.ADC_SAMPLE <= 1'b0;
               if (bus.ADC_DONE) begin
                  state        <= S_NEXT;
                  bus.fsm_stat <= stat_of(S_NEXT);
               end else if (timer == CONV_END) begin
                  bus.ERR_TIMEOUT <= 1'b1;
                  state           <= S_NEXT;
                  bus.fsm_stat    <= stat_of(S_NEXT);
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            S_NEXT: begin
               bus.ROW_EN <= 1'b0;
               bus.CntRow <= bus.CntRow + 32'd1;
               if (row == LAST_ROW) begin
                  bus.FSMIND0  <= 1'b1;
                  state        <= S_DONE;
                  bus.fsm_stat <= stat_of(S_DONE);
               end else begin
                  row          <= row + 8'd1;
                  state        <= S_ROW_SEL;
                  bus.fsm_stat <= stat_of(S_ROW_SEL);
               end
            end
            S_DONE: begin
               // FSMIND1 must be gone too, otherwise we would re-trigger on a stale request.
               if (bus.FSMIND0ACK && !bus.FSMIND1) begin
                  bus.FSMIND0    <= 1'b0;
                  bus.FSMIND1ACK <= 1'b0;
                  bus.CntFrame   <= bus.CntFrame + 32'd1;
                  state          <= S_IDLE;
                  bus.fsm_stat   <= STAT_IDLE;
               end
            end
            default: begin
               state          <= S_IDLE;
               bus.fsm_stat   <= STAT_IDLE;
               bus.FSMIND1ACK <= 1'b0;
               bus.FSMIND0    <= 1'b0;
               bus.ROW_EN     <= 1'b0;
               bus.ADC_SAMPLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_roimager_readout.sv
// Self-checking bench for roimager_readout: a timeline model of the frame sequence
// is compared every cycle, plus directed literal checks of frame length and status.
module tb_roimager_readout;

   localparam int NROWS   = 4;
   localparam int SETTLE  = 3;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   roimager_readout_if bus ();

   roimager_readout #(
      .C_NUM_ROWS   (NROWS),
      .C_ROW_SETTLE (SETTLE),
      .C_ADC_TIMEOUT(TIMEOUT)
   ) dut (
      .CLKMPRE(clk),
      .RESET  (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   int adc_lat = 2;
   bit spur = 1'b0;
   int n_samp = 0;
   int samp_addr [256];

   logic        m_ind1ack, m_ind0, m_row_en, m_sample, m_err;
   logic [7:0]  m_addr, m_stat;
   logic [31:0] m_cnt_row, m_cnt_frame;
   logic        i_rst, i_ind1, i_ack0, i_done;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the frame is a timeline of edges, one statement group per edge.
   task automatic model_reset();
      m_ind1ack = 0; m_ind0 = 0; m_row_en = 0; m_sample = 0; m_err = 0;
      m_addr = 0; m_stat = 8'hE0; m_cnt_row = 0; m_cnt_frame = 0;
   endtask

   task automatic model_edge(output bit hit);
      @(posedge clk);
      i_rst = rst; i_ind1 = bus.FSMIND1; i_ack0 = bus.FSMIND0ACK; i_done = bus.ADC_DONE;
      hit = i_rst;
      if (i_rst) model_reset();
   endtask

   task automatic model_frame();
      bit r;
      forever begin model_edge(r); if (r) return; if (i_ind1) break; end
      m_ind1ack = 1; m_cnt_row = 0; m_stat = 8'hE1;
      model_edge(r); if (r) return;
      m_stat = 8'hE2;
      for (int row = 0; row < NROWS; row++) begin
         int n;
         model_edge(r); if (r) return;
         m_addr = 8'(row); m_row_en = 1; m_stat = 8'hE3;
         for (int s = 0; s < SETTLE; s++) begin model_edge(r); if (r) return; end
         m_stat = 8'hE4;
         model_edge(r); if (r) return;
         m_sample = 1; m_stat = 8'hE5;
         n = 0;
         forever begin
            model_edge(r); if (r) return;
            m_sample = 0; n++;
            if (i_done) break;
            if (n == TIMEOUT) begin m_err = 1; break; end
         end
         m_stat = 8'hE6;
         model_edge(r); if (r) return;
         m_row_en = 0; m_cnt_row++;
         if (row == NROWS - 1) begin m_ind0 = 1; m_stat = 8'hE7; end
         else m_stat = 8'hE2;
      end
      forever begin model_edge(r); if (r) return; if (i_ack0 && !i_ind1) break; end
      m_ind0 = 0; m_ind1ack = 0; m_cnt_frame++; m_stat = 8'hE0;
   endtask

   initial begin
      model_reset();
      forever model_frame();
   end

   // ADC responder: fixed latency after the sample strobe, or random when adc_lat < 0.
   initial begin
      int cnt;
      cnt = 0;
      bus.ADC_DONE = 1'b0;
      forever begin
         @(negedge clk);
         if (adc_lat < 0) begin
            bus.ADC_DONE = ($urandom_range(0, 2) == 0);
         end else begin
            if (bus.ADC_SAMPLE) cnt = adc_lat;
            else if (cnt > 0) cnt--;
            bus.ADC_DONE = (cnt == 1) ||
               (spur && (bus.fsm_stat == 8'hE0 || bus.fsm_stat == 8'hE3) && $urandom_range(0, 1) == 1);
         end
      end
   end

   // Per-cycle compare against the model, plus the row-enable to sample spacing.
   initial begin
      logic prev_en, prev_samp;
      int gap;
      prev_en = 0; prev_samp = 0; gap = 0;
      forever begin
         @(negedge clk);
         if (check_en) begin
            check_output("FSMIND1ACK", bus.FSMIND1ACK, m_ind1ack);
            check_output("FSMIND0", bus.FSMIND0, m_ind0);
            check_output("ROW_ADDR", bus.ROW_ADDR, m_addr);
            check_output("ROW_EN", bus.ROW_EN, m_row_en);
            check_output("ADC_SAMPLE", bus.ADC_SAMPLE, m_sample);
            check_output("ERR_TIMEOUT", bus.ERR_TIMEOUT, m_err);
            check_output("CntRow", bus.CntRow, m_cnt_row);
            check_output("CntFrame", bus.CntFrame, m_cnt_frame);
            check_output("fsm_stat", bus.fsm_stat, m_stat);
            if (bus.ROW_EN && !prev_en) gap = 0;
            else gap++;
            if (bus.ADC_SAMPLE && !prev_samp) begin
               check_output("sample_gap", gap, SETTLE + 1);
               samp_addr[n_samp % 256] = int'(bus.ROW_ADDR);
               n_samp++;
            end
            prev_en = bus.ROW_EN;
            prev_samp = bus.ADC_SAMPLE;
         end
      end
   end

   // One exposure-side frame: request, wait for FSMIND0, acknowledge (unless held or aborted).
   task automatic apply_stimulus(input int lat, input bit hold, input int abort_at,
                                 output int cycles, output bit aborted);
      int n;
      adc_lat = lat;
      aborted = 0;
      @(negedge clk);
      bus.FSMIND0ACK = 1'b0;
      bus.FSMIND1 = 1'b1;
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (!hold && bus.FSMIND1ACK) bus.FSMIND1 = 1'b0;
         if (bus.FSMIND0 || cycles >= 1000) break;
         if (abort_at > 0 && cycles == abort_at) begin aborted = 1; return; end
      end
      check_output("frame_end_seen", bus.FSMIND0, 1);
      if (hold) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.FSMIND0ACK = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.FSMIND1ACK && n < 50);
      check_output("ack_release", bus.FSMIND1ACK, 0);
   endtask

   task automatic check_addrs(input int base);
      for (int i = 0; i < NROWS; i++)
         check_output($sformatf("row_order%0d", i), samp_addr[(base + i) % 256], i);
   endtask

   initial begin
      int cyc, base, n;
      bit ab;
      bus.FSMIND1 = 1'b0;
      bus.FSMIND0ACK = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_en = 1'b1;
      @(negedge clk);
      check_output("reset_stat", bus.fsm_stat, 8'hE0);
      check_output("reset_row_en", bus.ROW_EN, 0);
      check_output("reset_cnt_frame", bus.CntFrame, 0);
      check_output("reset_ind1ack", bus.FSMIND1ACK, 0);
      rst = 1'b0;

      // Nominal frame, ADC answers on the 2nd conversion cycle.
      base = n_samp;
      apply_stimulus(2, 0, 0, cyc, ab);
      check_output("nominal_cycles", cyc, 34);
      check_output("nominal_samples", n_samp - base, NROWS);
      check_addrs(base);
      check_output("nominal_cnt_row", bus.CntRow, 4);
      check_output("nominal_cnt_frame", bus.CntFrame, 1);
      check_output("nominal_err", bus.ERR_TIMEOUT, 0);

      // ADC never answers: every row times out, error stays sticky afterwards.
      apply_stimulus(0, 0, 0, cyc, ab);
      check_output("timeout_cycles", cyc, 58);
      check_output("timeout_err", bus.ERR_TIMEOUT, 1);
      apply_stimulus(2, 0, 0, cyc, ab);
      check_output("sticky_err", bus.ERR_TIMEOUT, 1);
      check_output("sticky_cnt_frame", bus.CntFrame, 3);

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_output("err_cleared", bus.ERR_TIMEOUT, 0);

      // ADC_DONE on the final allowed conversion cycle is a success.
      apply_stimulus(8, 0, 0, cyc, ab);
      check_output("edge_done_cycles", cyc, 58);
      check_output("edge_done_err", bus.ERR_TIMEOUT, 0);

      // FSMIND0ACK while FSMIND1 is still high must not release the frame.
      apply_stimulus(2, 1, 0, cyc, ab);
      bus.FSMIND0ACK = 1'b1;
      repeat (3) @(negedge clk);
      check_output("hold_ind0", bus.FSMIND0, 1);
      check_output("hold_stat", bus.fsm_stat, 8'hE7);
      bus.FSMIND1 = 1'b0;
      @(negedge clk);
      check_output("release_ind0", bus.FSMIND0, 0);
      check_output("release_ind1ack", bus.FSMIND1ACK, 0);
      check_output("release_stat", bus.fsm_stat, 8'hE0);

      // Reset during the first settle cycle of row 2.
      apply_stimulus(2, 0, 19, cyc, ab);
      check_output("abort_reached", ab, 1);
      check_output("abort_row", bus.ROW_ADDR, 2);
      check_output("abort_state", bus.fsm_stat, 8'hE3);
      rst = 1'b1;
      @(negedge clk);
      check_output("abort_row_en", bus.ROW_EN, 0);
      check_output("abort_ind1ack", bus.FSMIND1ACK, 0);
      check_output("abort_cnt_row", bus.CntRow, 0);
      check_output("abort_stat", bus.fsm_stat, 8'hE0);
      check_output("abort_no_ind0", bus.FSMIND0, 0);
      rst = 1'b0;
      base = n_samp;
      apply_stimulus(2, 0, 0, cyc, ab);
      check_output("restart_cycles", cyc, 34);
      check_addrs(base);

      // Spurious ADC_DONE in idle and settle must not disturb anything.
      spur = 1'b1;
      repeat (10) @(negedge clk);
      check_output("spur_idle_stat", bus.fsm_stat, 8'hE0);
      base = n_samp;
      apply_stimulus(2, 0, 0, cyc, ab);
      check_output("spur_cycles", cyc, 34);
      check_output("spur_cnt_row", bus.CntRow, 4);
      check_output("spur_samples", n_samp - base, NROWS);
      spur = 1'b0;

      // Randomized frames: latency, holds and occasional mid-frame resets.
      for (int f = 0; f < 10; f++) begin
         int r, lat, abort_at;
         bit hold;
         r = int'($urandom_range(0, 10));
         lat = (r == 10) ? -1 : r;
         hold = ($urandom_range(0, 2) == 0);
         abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
         apply_stimulus(lat, hold, abort_at, cyc, ab);
         if (ab) begin
            bus.FSMIND1 = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (hold) begin
            bus.FSMIND0ACK = 1'b1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.FSMIND1 = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (bus.FSMIND1ACK && n < 50);
            check_output("rand_release", bus.FSMIND1ACK, 0);
         end
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
